// File: rtl/sram_pkg.sv
// Shared types for the two-port SRAM: read-during-write policy and controller state.
package sram_pkg;

  typedef enum logic {
    RDW_WRITE_FIRST,
    RDW_READ_FIRST
  } rdw_mode_e;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-response pipeline: RD_LAT valid stages, trailing data stages that hold between reads.
module sram_rd_pipe #(
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [DATA_W-1:0] ram_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  logic [RD_LAT-1:0] valid_reg;

  genvar gi;
  for (gi = 0; gi < RD_LAT; gi++) begin : g_valid
    if (gi == 0) begin : g_first
      always_ff @(posedge clk) begin
        if (rst) valid_reg[gi] <= 1'b0;
        else     valid_reg[gi] <= req;
      end
    end else begin : g_next
      always_ff @(posedge clk) begin
        if (rst) valid_reg[gi] <= 1'b0;
        else     valid_reg[gi] <= valid_reg[gi-1];
      end
    end
  end

  // ram_data already comes from a register, so only latencies above 1 add data stages.
  if (RD_LAT == 1) begin : g_lat1
    assign rd_data = ram_data;
  end else begin : g_lat2
    logic [DATA_W-1:0] data_reg;
    always_ff @(posedge clk) begin
      if (rst)               data_reg <= '0;
      else if (valid_reg[0]) data_reg <= ram_data;
    end
    assign rd_data = data_reg;
  end

  assign rd_valid = valid_reg[RD_LAT-1];

endmodule

// File: rtl/sram_2p.sv
// Simple dual-port SRAM with byte enables, post-reset zero sweep and selectable
// same-address read-during-write behaviour.
module sram_2p
  import sram_pkg::*;
#(
  parameter int        DATA_W   = 16,
  parameter int        DEPTH    = 16,
  parameter int        RD_LAT   = 1,
  parameter rdw_mode_e RDW_MODE = RDW_WRITE_FIRST,
  localparam int       ADDR_W   = $clog2(DEPTH),
  localparam int       NB       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [NB-1:0]     wr_be,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  if (DATA_W % 8 != 0) begin : g_chk_width
    $error("sram_2p: DATA_W must be a multiple of 8");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_chk_lat
    $error("sram_2p: RD_LAT must be 1 or 2");
  end
  if (DEPTH < 2) begin : g_chk_depth
    $error("sram_2p: DEPTH must be at least 2");
  end

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic              init_busy_reg;

  logic              wr_in_range, rd_in_range, ready, wr_fire, rd_fire;
  logic [DATA_W-1:0] wr_mask;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NB-1:0]     mem_wbe;

  logic [DATA_W-1:0] ram_q_reg, byp_data_reg, byp_mask_reg;
  logic              oob_reg;
  logic [DATA_W-1:0] ram_word;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_C;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_C;
  assign ready       = (state_reg == ST_READY) && !rst;
  assign wr_fire     = ready && wr_en && wr_in_range;
  assign rd_fire     = ready && rd_en;

  genvar gi;
  for (gi = 0; gi < NB; gi++) begin : g_mask
    assign wr_mask[8*gi +: 8] = {8{wr_be[gi]}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_INIT;
      cnt_reg       <= '0;
      init_busy_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_INIT: begin
          if (cnt_reg == LAST_C) begin
            state_reg     <= ST_READY;
            init_busy_reg <= 1'b0;
            cnt_reg       <= '0;
          end else begin
            cnt_reg <= cnt_reg + ADDR_W'(1);
          end
        end
        default: state_reg <= ST_READY;
      endcase
    end
  end

  assign init_busy = init_busy_reg;

  // The clear sweep and user writes share the single write port.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    mem_wbe   = wr_be;
    if (state_reg == ST_INIT) begin
      mem_we    = !rst;
      mem_waddr = cnt_reg;
      mem_wdata = '0;
      mem_wbe   = '1;
    end else begin
      mem_we    = wr_fire;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (mem_we && mem_wbe[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // The array read is always read-first; write-first is recovered by merging
  // the colliding write's enabled lanes on the output side.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_q_reg    <= '0;
      byp_data_reg <= '0;
      byp_mask_reg <= '0;
      oob_reg      <= 1'b0;
    end else if (rd_fire) begin
      ram_q_reg    <= mem[rd_addr];
      byp_data_reg <= wr_data;
      byp_mask_reg <= (RDW_MODE == RDW_WRITE_FIRST && wr_fire && wr_addr == rd_addr)
                      ? wr_mask : '0;
      oob_reg      <= !rd_in_range;
    end
  end

  assign ram_word = oob_reg ? '0
                  : ((ram_q_reg & ~byp_mask_reg) | (byp_data_reg & byp_mask_reg));

  sram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .req      (rd_fire),
    .ram_data (ram_word),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

endmodule

// File: tb/tb_sram_2p.sv
// Two SRAM configurations driven in parallel and checked against a word-level memory model.
module tb_sram_2p;
  import sram_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr_en, rd_en;
  logic [3:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic        busy_a, busy_b, v_a, v_b;
  logic [15:0] d_a, d_b;

  sram_2p #(.DATA_W(16), .DEPTH(16), .RD_LAT(1), .RDW_MODE(RDW_WRITE_FIRST)) u_dut_a (
    .clk(clk), .rst(rst), .init_busy(busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(v_a), .rd_data(d_a));

  sram_2p #(.DATA_W(16), .DEPTH(12), .RD_LAT(2), .RDW_MODE(RDW_READ_FIRST)) u_dut_b (
    .clk(clk), .rst(rst), .init_busy(busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(v_b), .rd_data(d_b));

  int checks = 0;
  int errors = 0;

  // Model: per-instance config, word array, cycles since reset release, and
  // the result expected on the outputs now (plus one queued for latency 2).
  int          depth_m [2] = '{16, 12};
  int          lat_m   [2] = '{1, 2};
  bit          rf_m    [2] = '{1'b0, 1'b1};
  logic [15:0] mm      [2][16];
  int          since   [2];
  bit          started [2] = '{1'b0, 1'b0};
  bit          exp_busy[2];
  bit          cur_v   [2];
  logic [15:0] cur_d   [2];
  bit          nxt_v   [2];
  logic [15:0] nxt_d   [2];
  bit          res_v;
  logic [15:0] res_d;

  function automatic logic [15:0] merge(logic [15:0] old_w, logic [15:0] new_w, logic [1:0] be);
    logic [15:0] r;
    r = old_w;
    if (be[0]) r[7:0]  = new_w[7:0];
    if (be[1]) r[15:8] = new_w[15:8];
    return r;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      res_v = 1'b0;
      res_d = 16'h0;
      if (rst) begin
        started[i] = 1'b1;
        since[i]   = 0;
        cur_v[i]   = 1'b0;
        cur_d[i]   = 16'h0;
        nxt_v[i]   = 1'b0;
      end else if (started[i]) begin
        if (since[i] < depth_m[i]) begin
          mm[i][since[i]] = 16'h0;
          since[i]++;
        end else begin
          if (rd_en && rf_m[i]) begin
            res_v = 1'b1;
            res_d = (int'(rd_addr) < depth_m[i]) ? mm[i][rd_addr] : 16'h0;
          end
          if (wr_en && int'(wr_addr) < depth_m[i])
            mm[i][wr_addr] = merge(mm[i][wr_addr], wr_data, wr_be);
          if (rd_en && !rf_m[i]) begin
            res_v = 1'b1;
            res_d = (int'(rd_addr) < depth_m[i]) ? mm[i][rd_addr] : 16'h0;
          end
        end
        if (lat_m[i] == 1) begin
          cur_v[i] = res_v;
          if (res_v) cur_d[i] = res_d;
        end else begin
          cur_v[i] = nxt_v[i];
          if (nxt_v[i]) cur_d[i] = nxt_d[i];
          nxt_v[i] = res_v;
          nxt_d[i] = res_d;
        end
      end
      exp_busy[i] = rst || (since[i] < depth_m[i]);
    end
  end

  task automatic chk(input string name, input int inst, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d actual %h required %h at %0t", name, inst, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started[0]) begin
      chk("model_busy", 0, {15'b0, busy_a}, {15'b0, exp_busy[0]});
      chk("model_valid", 0, {15'b0, v_a}, {15'b0, cur_v[0]});
      chk("model_data", 0, d_a, cur_d[0]);
    end
    if (started[1]) begin
      chk("model_busy", 1, {15'b0, busy_b}, {15'b0, exp_busy[1]});
      chk("model_valid", 1, {15'b0, v_b}, {15'b0, cur_v[1]});
      chk("model_data", 1, d_b, cur_d[1]);
    end
  end

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    @(negedge clk);
    wr_en = 1'b0;
    $display("write addr %h data %h be %b", a, d, be);
  endtask

  task automatic rd_lit(input logic [3:0] a, input logic [15:0] ea, input logic [15:0] eb);
    bit ga, gb;
    logic [15:0] sa, sb;
    ga = 1'b0; gb = 1'b0; sa = 16'h0; sb = 16'h0;
    @(negedge clk);
    rd_en = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (v_a && !ga) begin ga = 1'b1; sa = d_a; chk("lit_rd_data", 0, d_a, ea); end
      if (v_b && !gb) begin gb = 1'b1; sb = d_b; chk("lit_rd_data", 1, d_b, eb); end
      @(negedge clk);
    end
    chk("lit_rd_seen", 0, {15'b0, ga}, 16'h1);
    chk("lit_rd_seen", 1, {15'b0, gb}, 16'h1);
    $display("read addr %h -> a %h b %h", a, sa, sb);
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 40 && (busy_a || busy_b); k++) @(negedge clk);
    chk("ready_timeout", 0, {14'b0, busy_a, busy_b}, 16'h0);
  endtask

  int na, nb, nva, nvb;
  logic [15:0] seq [3] = '{16'h0011, 16'h0022, 16'h0033};

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 0, {15'b0, busy_a}, 16'h1);
    chk("rst_valid", 1, {15'b0, v_b}, 16'h0);
    chk("rst_data", 0, d_a, 16'h0);

    // Reads during the sweep must all be dropped.
    rst = 1'b0; rd_en = 1'b1; rd_addr = 4'd3;
    na = 0; nb = 0; nva = 0; nvb = 0;
    for (int k = 0; k < 40 && busy_a; k++) begin
      na++;
      if (busy_b) nb++;
      if (v_a) nva++;
      if (v_b && busy_b) nvb++;
      @(negedge clk);
    end
    rd_en = 1'b0;
    chk("sweep_len", 0, 16'(na), 16'd16);
    chk("sweep_len", 1, 16'(nb), 16'd12);
    chk("sweep_no_valid", 0, 16'(nva), 16'd0);
    chk("sweep_no_valid", 1, 16'(nvb), 16'd0);
    $display("sweep cycles a %0d b %0d", na, nb);
    repeat (4) @(negedge clk);
    rd_lit(4'd3, 16'h0000, 16'h0000);

    wr(4'd4, 16'hBEEF, 2'b11);
    wr(4'd4, 16'h12AA, 2'b01);
    rd_lit(4'd4, 16'hBEAA, 16'hBEAA);

    wr(4'd1, 16'h0011, 2'b11);
    wr(4'd2, 16'h0022, 2'b11);
    wr(4'd3, 16'h0033, 2'b11);
    @(negedge clk);
    rd_en = 1'b1; rd_addr = 4'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("b2b_valid", 0, {15'b0, v_a}, (k < 3) ? 16'h1 : 16'h0);
      if (k < 3) chk("b2b_data", 0, d_a, seq[k]);
      chk("b2b_valid", 1, {15'b0, v_b}, (k >= 1 && k <= 3) ? 16'h1 : 16'h0);
      if (k >= 1 && k <= 3) chk("b2b_data", 1, d_b, seq[k-1]);
      if (k < 2) rd_addr = 4'(k + 2);
      else       rd_en = 1'b0;
    end
    $display("back-to-back reads addr 1..3 done");

    wr(4'd7, 16'h1111, 2'b11);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h2222; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 4'd7;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rdw_valid", 0, {15'b0, v_a}, 16'h1);
    chk("rdw_data", 0, d_a, 16'h2222);
    @(negedge clk);
    chk("rdw_valid", 1, {15'b0, v_b}, 16'h1);
    chk("rdw_data", 1, d_b, 16'h1111);
    $display("read-during-write addr 7 -> a %h b %h", d_a, d_b);
    repeat (2) @(negedge clk);

    wr(4'd13, 16'h5555, 2'b11);
    rd_lit(4'd13, 16'h5555, 16'h0000);
    rd_lit(4'd0, 16'h0000, 16'h0000);
    rd_lit(4'd1, 16'h0011, 16'h0011);

    // Reset lands while instance b still has a read in flight.
    wr(4'd9, 16'hCAFE, 2'b11);
    @(negedge clk);
    rd_en = 1'b1; rd_addr = 4'd9;
    @(negedge clk);
    rd_en = 1'b0; rst = 1'b1;
    chk("flush_valid", 0, {15'b0, v_a}, 16'h1);
    chk("flush_data", 0, d_a, 16'hCAFE);
    chk("flush_valid", 1, {15'b0, v_b}, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("flush_valid_rst", 0, {15'b0, v_a}, 16'h0);
    chk("flush_valid_rst", 1, {15'b0, v_b}, 16'h0);
    chk("flush_data_rst", 1, d_b, 16'h0);
    $display("reset with read in flight");
    wait_ready();
    rd_lit(4'd9, 16'h0000, 16'h0000);

    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      rst     = ($urandom_range(0, 299) == 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 16'($urandom);
      wr_be   = 2'($urandom_range(0, 3));
      rd_en   = $urandom_range(0, 1);
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
